// File: rtl/adc128s052_scan_ctrl.sv
// adc128s052_scan_ctrl
// Scanning controller for the ADC128S052 8-channel 12-bit SPI ADC.
// It runs a PRIME frame to load the first address. It then runs CONV frames
// that each return the conversion addressed one frame earlier. Every result
// is tagged with its true channel and leaves on a one-deep valid/ready stream.
//
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   start          one-cycle pulse, begins a scan when idle with a non-empty mask
//   stop           one-cycle pulse, finish the current frame then stop
//   mode           0 = single scan, 1 = continuous (latched on start)
//   ch_mask[7:0]   channel enables (latched on start, bits >= NUM_CH ignored)
//   sclk, cs_n     ADC serial clock (idles high) and chip select
//   mosi, miso     ADC DIN (address) and DOUT (data)
//   m_valid/m_ready/m_channel/m_data   result stream
//   busy           scan in progress, including the cs_n gap
//   overrun        sticky, a result was dropped
//
// Stream handshake: a result transfers on a clk edge where m_valid and
// m_ready are both high. m_channel and m_data hold while m_valid is high and
// m_ready is low. A new result loads only into an empty or draining holding
// register. Otherwise it is dropped and overrun is set.
module adc128s052_scan_ctrl #(
  parameter int CLK_DIV = 1,
  parameter int NUM_CH  = 8,
  parameter int CS_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        mode,
  input  logic [7:0]  ch_mask,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [2:0]  m_channel,
  output logic [11:0] m_data,
  output logic        busy,
  output logic        overrun
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
  localparam logic [7:0] RANGE = (NUM_CH >= 8) ? 8'hFF : 8'((1 << NUM_CH) - 1);

  typedef enum logic [1:0] {IDLE, PRIME, CONV, GAP} state_t;

  // Next enabled channel after cur in ascending order, wrapping. With
  // cur = 7 this yields the lowest enabled channel.
  function automatic logic [2:0] next_en(input logic [2:0] cur, input logic [7:0] m);
    logic [2:0] r;
    logic [2:0] c;
    logic       found;
    r     = cur;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      c = cur + 3'(i);
      if (!found && m[c]) begin
        r     = c;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q;
  logic [GW-1:0]   gap_q;
  logic [4:0]      fcnt_q;      // falling edges seen in the current frame
  logic            sclk_q, cs_n_q, mosi_q;
  logic [7:0]      mask_q;
  logic            mode_q, stop_q;
  logic [2:0]      low_ch_q;    // lowest enabled channel
  logic [2:0]      nxt_ch_q;    // address sent in the current frame
  logic [2:0]      cur_ch_q;    // channel whose data returns in the current frame
  logic [11:0]     sh_q;
  logic            pend_q;      // CONV frame data complete, emit this cycle
  logic            m_valid_q, overrun_q;
  logic [2:0]      m_channel_q;
  logic [11:0]     m_data_q;

  logic [7:0] masked;
  logic       accept, active, tick, fall_ev, rise_ev, frame_end, to_gap;

  always_comb begin
    masked    = ch_mask & RANGE;
    accept    = (state_q == IDLE) && start && (masked != 8'h00);
    active    = (state_q == PRIME) || (state_q == CONV);
    tick      = (div_q == DIV_LAST);
    fall_ev   = active && tick && sclk_q;
    rise_ev   = active && tick && !sclk_q;
    // The 17th falling edge is the boundary. It is either falling edge 1 of
    // the next frame or the point where cs_n is released.
    frame_end = fall_ev && (fcnt_q == 5'd16);
    state_d   = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = PRIME;
      PRIME: if (frame_end) state_d = (stop_q || stop) ? GAP : CONV;
      CONV:  if (frame_end) state_d = (stop_q || stop || (!mode_q && nxt_ch_q == low_ch_q)) ? GAP : CONV;
      GAP:   if (gap_q == GAP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    to_gap = frame_end && (state_d == GAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      gap_q       <= '0;
      fcnt_q      <= 5'd0;
      sclk_q      <= 1'b1;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      mask_q      <= 8'h00;
      mode_q      <= 1'b0;
      stop_q      <= 1'b0;
      low_ch_q    <= 3'd0;
      nxt_ch_q    <= 3'd0;
      cur_ch_q    <= 3'd0;
      sh_q        <= 12'h000;
      pend_q      <= 1'b0;
      m_valid_q   <= 1'b0;
      overrun_q   <= 1'b0;
      m_channel_q <= 3'd0;
      m_data_q    <= 12'h000;
    end else begin
      state_q <= state_d;
      pend_q  <= rise_ev && (fcnt_q == 5'd16) && (state_q == CONV);

      if (accept) begin
        mask_q   <= masked;
        mode_q   <= mode;
        low_ch_q <= next_en(3'd7, masked);
        nxt_ch_q <= next_en(3'd7, masked);
        cs_n_q   <= 1'b0;
        sclk_q   <= 1'b1;
        div_q    <= '0;
        fcnt_q   <= 5'd0;
        stop_q   <= 1'b0;
      end

      if (active) begin
        div_q <= tick ? '0 : div_q + DW'(1);
        if (stop) stop_q <= 1'b1;
        if (to_gap) begin
          cs_n_q <= 1'b1;
          mosi_q <= 1'b0;
          gap_q  <= '0;
          stop_q <= 1'b0;
        end else if (fall_ev) begin
          sclk_q <= 1'b0;
          if (frame_end) begin
            fcnt_q   <= 5'd1;
            cur_ch_q <= nxt_ch_q;
            nxt_ch_q <= next_en(nxt_ch_q, mask_q);
            mosi_q   <= 1'b0;
          end else begin
            fcnt_q <= fcnt_q + 5'd1;
            // Falling edges 3..5 carry ADD2..ADD0.
            case (fcnt_q)
              5'd2:    mosi_q <= nxt_ch_q[2];
              5'd3:    mosi_q <= nxt_ch_q[1];
              5'd4:    mosi_q <= nxt_ch_q[0];
              default: mosi_q <= 1'b0;
            endcase
          end
        end else if (rise_ev) begin
          sclk_q <= 1'b1;
          // Rising edges 1..4 carry leading zeros from the ADC.
          if (fcnt_q >= 5'd5) sh_q <= {sh_q[10:0], miso};
        end
      end

      if (state_q == GAP) gap_q <= gap_q + GW'(1);

      if (pend_q && (!m_valid_q || m_ready)) begin
        m_valid_q   <= 1'b1;
        m_data_q    <= sh_q;
        m_channel_q <= cur_ch_q;
      end else if (pend_q) begin
        overrun_q <= 1'b1;
      end else if (m_valid_q && m_ready) begin
        m_valid_q <= 1'b0;
      end

      if (accept) overrun_q <= 1'b0;
    end
  end

  assign sclk      = sclk_q;
  assign cs_n      = cs_n_q;
  assign mosi      = mosi_q;
  assign m_valid   = m_valid_q;
  assign m_channel = m_channel_q;
  assign m_data    = m_data_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

endmodule
